rx_sync_ctrl: RTL

//  Receive-side link synchronisation controller for the 8b/10b decoder path.

---
 rtl/rx_sync_ctrl_pkg.sv | 24 ++
 rtl/rx_sync_ctrl_comma_detect.sv | 12 +
 rtl/rx_sync_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rx_sync_ctrl_pkg.sv
// Shared definitions for the 8b/10b receive synchronisation controller:
// link state encodings, K28.5 reference codes and comma prefixes.
package rx_sync_ctrl_pkg;

  typedef enum logic [2:0] {
    LOSS_OF_SYNC = 3'd0,
    COMMA_ACQ    = 3'd1,
    SYNC_ACQ_1   = 3'd2,
    SYNC_ACQ_2   = 3'd3,
    SYNC_ACQ_3   = 3'd4,
    SYNC_ACQ_4   = 3'd5
  } link_state_e;

  localparam logic [9:0] K28_5_RDN   = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP   = 10'b1100000101;
  localparam logic [6:0] COMMA_PFX_P = 7'b0011111;
  localparam logic [6:0] COMMA_PFX_N = 7'b1100000;

  function automatic logic is_sync(input link_state_e s);
    return (s == SYNC_ACQ_1) || (s == SYNC_ACQ_2) ||
           (s == SYNC_ACQ_3) || (s == SYNC_ACQ_4);
  endfunction

endpackage

// File: rtl/rx_sync_ctrl_comma_detect.sv
// Combinational comma match on the 7-bit prefix (abcdeif) of a 10b symbol;
// covers K28.1, K28.5 and K28.7 in both running disparities.
module rx_sync_ctrl_comma_detect
  import rx_sync_ctrl_pkg::*;
(
  input  logic [6:0] sym_prefix,
  output logic       comma
);

  assign comma = (sym_prefix == COMMA_PFX_P) || (sym_prefix == COMMA_PFX_N);

endmodule

// File: rtl/rx_sync_ctrl.sv
// Receive link synchronisation controller: comma acquisition, error
// hysteresis FSM, data qualification and saturating error count.
module rx_sync_ctrl
  import rx_sync_ctrl_pkg::*;
#(
  parameter int ACQ_COMMAS = 3,
  parameter int GOOD_RUN   = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 BitCLK_10,
  input  logic                 Reset,
  input  logic [9:0]           RxParallel_10,
  input  logic                 SymbolValid,
  input  logic                 CodeErr,
  input  logic                 ResyncReq,
  input  logic                 ErrCountClr,
  output logic                 SyncAcquired,
  output logic                 RxDataValid,
  output logic                 CommaDet,
  output logic [2:0]           LinkState,
  output logic [ERR_CNT_W-1:0] ErrCount
);

  localparam logic [2:0]           ACQ_N   = 3'(ACQ_COMMAS);
  localparam logic [3:0]           GOOD_N  = 4'(GOOD_RUN);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  link_state_e          state_q, state_d;
  logic [2:0]           comma_cnt_q, comma_cnt_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic                 sync_q, sync_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 comma_det_q, comma_det_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 comma, sym_ok, sym_err, in_sync;
  logic                 unused_sym_bits;

  rx_sync_ctrl_comma_detect u_comma_detect (
    .sym_prefix (RxParallel_10[9:3]),
    .comma      (comma)
  );

  // Low symbol bits carry no comma information.
  assign unused_sym_bits = ^RxParallel_10[2:0];

  assign sym_ok  = SymbolValid & ~CodeErr;
  assign sym_err = SymbolValid & CodeErr;
  assign in_sync = is_sync(state_q);

  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      state_q     <= LOSS_OF_SYNC;
      comma_cnt_q <= '0;
      good_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (ResyncReq) begin
      state_d = LOSS_OF_SYNC;
    end else begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (sym_ok && comma) begin
            comma_cnt_d = 3'd1;
            state_d     = (ACQ_N == 3'd1) ? SYNC_ACQ_1 : COMMA_ACQ;
          end
        end
        COMMA_ACQ: begin
          if (sym_err) begin
            state_d = LOSS_OF_SYNC;
          end else if (sym_ok && comma) begin
            if (comma_cnt_q + 3'd1 == ACQ_N) begin
              comma_cnt_d = '0;
              state_d     = SYNC_ACQ_1;
            end else begin
              comma_cnt_d = comma_cnt_q + 3'd1;
            end
          end
        end
        SYNC_ACQ_1: begin
          if (sym_err) begin
            good_cnt_d = '0;
            state_d    = SYNC_ACQ_2;
          end
        end
        SYNC_ACQ_2, SYNC_ACQ_3, SYNC_ACQ_4: begin
          // An error always beats completion of a good run on the same symbol.
          if (sym_err) begin
            good_cnt_d = '0;
            case (state_q)
              SYNC_ACQ_2: state_d = SYNC_ACQ_3;
              SYNC_ACQ_3: state_d = SYNC_ACQ_4;
              default:    state_d = LOSS_OF_SYNC;
            endcase
          end else if (sym_ok) begin
            if (good_cnt_q + 4'd1 == GOOD_N) begin
              good_cnt_d = '0;
              case (state_q)
                SYNC_ACQ_4: state_d = SYNC_ACQ_3;
                SYNC_ACQ_3: state_d = SYNC_ACQ_2;
                default:    state_d = SYNC_ACQ_1;
              endcase
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end
    if (state_d == LOSS_OF_SYNC) begin
      comma_cnt_d = '0;
      good_cnt_d  = '0;
    end
  end

  always_comb begin
    sync_d      = is_sync(state_d);
    rx_valid_d  = sym_ok & in_sync & ~ResyncReq;
    comma_det_d = rx_valid_d & comma;
    err_cnt_d   = err_cnt_q;
    if (ErrCountClr) begin
      err_cnt_d = '0;
    end else if (sym_err && in_sync && !ResyncReq && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      sync_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      comma_det_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync_q      <= sync_d;
      rx_valid_q  <= rx_valid_d;
      comma_det_q <= comma_det_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign SyncAcquired = sync_q;
  assign RxDataValid  = rx_valid_q;
  assign CommaDet     = comma_det_q;
  assign LinkState    = state_q;
  assign ErrCount     = err_cnt_q;

endmodule
